// File: rtl/alu_execute.sv
// alu_execute
//   Execute stage for RISC-V style integer ALU operations. Accepts one
//   operand bundle at a time with a valid/ready handshake and presents a
//   registered RESULT with OUT_VALID/OUT_READY backpressure.
//
//   ADD/SUB, SLT, SLTU, XOR, OR and AND finish one edge after accept.
//   Shifts (SLL, SRL, SRA) normally shift one bit per cycle in the SHIFT
//   state. A shift amount of 0 finishes in one edge like the other ops.
//
//   Optional feature macro: ALU_EXECUTE_FAST_SHIFT_EN
//     When defined, shifts use a single-cycle barrel shifter and the
//     SHIFT state is never entered.
//
// Ports
//   CLK        in   sole clock, rising edge
//   RST        in   synchronous active-high reset
//   IN_VALID   in   operand bundle valid
//   IN_READY   out  bundle can be accepted this cycle
//   DATA0/1    in   32-bit operands
//   ALU_EN     in   bundle carries an ALU operation (0: consume silently)
//   OPCODE     in   7-bit major opcode
//   FUNCT3     in   3-bit operation select
//   FUNCT7_5   in   instruction bit 30 (SUB / SRA select)
//   RESULT     out  registered result, holds its last value
//   OUT_VALID  out  RESULT valid
//   OUT_READY  in   downstream accepts RESULT
module alu_execute (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] DATA0,
  input  logic [31:0] DATA1,
  input  logic        ALU_EN,
  input  logic [6:0]  OPCODE,
  input  logic [2:0]  FUNCT3,
  input  logic        FUNCT7_5,
  output logic [31:0] RESULT,
  output logic        OUT_VALID,
  input  logic        OUT_READY
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] result_q, result_d;

  logic        is_reg, is_imm;
  logic [4:0]  shift_amt;
  logic [31:0] alu_value;
  logic        accept;

`ifndef ALU_EXECUTE_FAST_SHIFT_EN
  logic [4:0]  shift_cnt_q, shift_cnt_d;
  logic        shift_left_q, shift_left_d;
  logic        shift_arith_q, shift_arith_d;
  logic        is_shift, shift_left, shift_arith;
`endif

  assign IN_READY  = ~RST & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & OUT_READY));
  assign accept    = IN_VALID & IN_READY;
  assign OUT_VALID = (state_q == ST_DONE);
  assign RESULT    = result_q;

  // Operation decode. Opcodes other than OP and OP-IMM fall back to ADD.
  // For iterative shifts alu_value is DATA0, which is also the correct
  // answer for a zero shift amount.
  always_comb begin
    is_reg    = (OPCODE == 7'b0110011);
    is_imm    = (OPCODE == 7'b0010011);
    shift_amt = DATA1[4:0];
    alu_value = DATA0 + DATA1;
`ifndef ALU_EXECUTE_FAST_SHIFT_EN
    is_shift    = 1'b0;
    shift_left  = 1'b0;
    shift_arith = 1'b0;
`endif
    if (is_reg || is_imm) begin
      case (FUNCT3)
        3'b000: alu_value = (is_reg && FUNCT7_5) ? (DATA0 - DATA1) : (DATA0 + DATA1);
        3'b001: begin
`ifdef ALU_EXECUTE_FAST_SHIFT_EN
          alu_value = DATA0 << shift_amt;
`else
          alu_value  = DATA0;
          is_shift   = 1'b1;
          shift_left = 1'b1;
`endif
        end
        3'b010: alu_value = {31'b0, ($signed(DATA0) < $signed(DATA1))};
        3'b011: alu_value = {31'b0, (DATA0 < DATA1)};
        3'b100: alu_value = DATA0 ^ DATA1;
        3'b101: begin
`ifdef ALU_EXECUTE_FAST_SHIFT_EN
          alu_value = FUNCT7_5 ? ($signed(DATA0) >>> shift_amt) : (DATA0 >> shift_amt);
`else
          alu_value   = DATA0;
          is_shift    = 1'b1;
          shift_arith = FUNCT7_5;
`endif
        end
        3'b110: alu_value = DATA0 | DATA1;
        default: alu_value = DATA0 & DATA1;
      endcase
    end
  end

  // Next-state logic. Leaving DONE retires the output; a bundle accepted on
  // the same edge starts immediately so there is no bubble. An ALU_EN=0
  // bundle is consumed and leaves the block idle.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
`ifndef ALU_EXECUTE_FAST_SHIFT_EN
    shift_cnt_d   = shift_cnt_q;
    shift_left_d  = shift_left_q;
    shift_arith_d = shift_arith_q;
`endif
    case (state_q)
      ST_SHIFT: begin
`ifdef ALU_EXECUTE_FAST_SHIFT_EN
        state_d = ST_IDLE;
`else
        result_d    = shift_left_q ? {result_q[30:0], 1'b0}
                                   : {(shift_arith_q & result_q[31]), result_q[31:1]};
        shift_cnt_d = shift_cnt_q - 5'd1;
        if (shift_cnt_q == 5'd1) state_d = ST_DONE;
`endif
      end
      ST_DONE: begin
        if (OUT_READY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      state_d = ST_IDLE;
      if (ALU_EN) begin
        result_d = alu_value;
        state_d  = ST_DONE;
`ifndef ALU_EXECUTE_FAST_SHIFT_EN
        if (is_shift && (shift_amt != 5'd0)) begin
          shift_cnt_d   = shift_amt;
          shift_left_d  = shift_left;
          shift_arith_d = shift_arith;
          state_d       = ST_SHIFT;
        end
`endif
      end
    end
  end

  // State registers with synchronous reset; reset aborts any operation.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      result_q <= 32'h0;
`ifndef ALU_EXECUTE_FAST_SHIFT_EN
      shift_cnt_q   <= 5'd0;
      shift_left_q  <= 1'b0;
      shift_arith_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
`ifndef ALU_EXECUTE_FAST_SHIFT_EN
      shift_cnt_q   <= shift_cnt_d;
      shift_left_q  <= shift_left_d;
      shift_arith_q <= shift_arith_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_execute.sv
// Self-checking bench for alu_execute. Expected results are queued when a
// bundle is accepted and compared when the DUT hands a result downstream.
module tb_alu_execute;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] DATA0, DATA1;
  logic        ALU_EN;
  logic [6:0]  OPCODE;
  logic [2:0]  FUNCT3;
  logic        FUNCT7_5;
  logic [31:0] RESULT;
  logic        OUT_VALID;
  logic        OUT_READY;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

`ifdef ALU_EXECUTE_FAST_SHIFT_EN
  localparam int SRAI_LAT = 1;
`else
  localparam int SRAI_LAT = 5;
`endif

  int          nChecks = 0;
  int          nFails  = 0;
  int          cycle   = 0;
  bit          randomReady = 1'b0;
  logic [31:0] expQ[$];

  alu_execute dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .DATA0(DATA0), .DATA1(DATA1), .ALU_EN(ALU_EN), .OPCODE(OPCODE),
    .FUNCT3(FUNCT3), .FUNCT7_5(FUNCT7_5), .RESULT(RESULT),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
  );

  // Free-running clock and edge counter used for latency measurement.
  always #5 CLK = ~CLK;
  always @(posedge CLK) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Reference behaviour of one ALU bundle.
  function automatic logic [31:0] expModel(input logic [6:0] op, input logic [2:0] f3,
                                           input logic f7, input logic [31:0] a, input logic [31:0] b);
    int amt;
    amt = int'(b[4:0]);
    if (op != OP_R && op != OP_I) return a + b;
    case (f3)
      3'b000: return (op == OP_R && f7) ? a - b : a + b;
      3'b001: return a << amt;
      3'b010: return ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
      3'b011: return (a < b) ? 32'h1 : 32'h0;
      3'b100: return a ^ b;
      3'b101: return f7 ? 32'($signed(a) >>> amt) : a >> amt;
      3'b110: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Scoreboard: every result handed downstream is compared to the queue.
  always @(negedge CLK) begin
    if (RST === 1'b0 && OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
      if (expQ.size() == 0) checkOutput("unexpected_out", 32'(OUT_VALID), 32'h0);
      else checkOutput("result", RESULT, expQ.pop_front());
    end
  end

  // Drives one bundle, starting just after a rising edge, and holds it
  // until accepted. Returns the edge number of acceptance.
  task automatic applyStimulus(input logic en, input logic [6:0] op, input logic [2:0] f3,
                               input logic f7, input logic [31:0] a, input logic [31:0] b,
                               input bit pushExp, input logic [31:0] expected,
                               output int acceptCycle, output int waited);
    bit done;
    done = 1'b0;
    waited = 0;
    ALU_EN = en; OPCODE = op; FUNCT3 = f3; FUNCT7_5 = f7; DATA0 = a; DATA1 = b;
    IN_VALID = 1'b1;
    while (!done) begin
      @(negedge CLK);
      if (IN_READY === 1'b1) begin
        done = 1'b1;
        if (pushExp) expQ.push_back(expected);
      end else if (waited >= 200) begin
        done = 1'b1;
        checkOutput("accept_timeout", 32'(waited), 32'h0);
      end else begin
        waited++;
        @(posedge CLK); #1;
        if (randomReady) OUT_READY = 1'($urandom_range(0, 1));
      end
    end
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    DATA0 = $urandom; DATA1 = $urandom;
    acceptCycle = cycle;
    if (randomReady) OUT_READY = 1'($urandom_range(0, 1));
  endtask

  // Waits (bounded) for OUT_VALID and returns latency in edges from accept.
  task automatic waitOutput(input int acceptCycle, input int maxCycles, input bit checkBusy, output int lat);
    int n;
    n = 0;
    @(negedge CLK);
    while (OUT_VALID !== 1'b1 && n < maxCycles) begin
      if (checkBusy) checkOutput("in_ready_busy", 32'(IN_READY), 32'h0);
      n++;
      @(negedge CLK);
    end
    if (OUT_VALID !== 1'b1) begin
      checkOutput("out_timeout", 32'(n), 32'h0);
      lat = -1;
    end else begin
      lat = cycle - acceptCycle + 1;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc, w, lat, n;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7, en;
    logic [31:0] a, b;

    RST = 1'b1; IN_VALID = 1'b0; ALU_EN = 1'b0; OPCODE = '0; FUNCT3 = '0;
    FUNCT7_5 = 1'b0; DATA0 = '0; DATA1 = '0; OUT_READY = 1'b1;

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkOutput("rst_out_valid", 32'(OUT_VALID), 32'h0);
    checkOutput("rst_result", RESULT, 32'h0);
    checkOutput("rst_in_ready", 32'(IN_READY), 32'h0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    checkOutput("post_rst_in_ready", 32'(IN_READY), 32'h1);
    @(posedge CLK); #1;

    // ADD wraps modulo 2^32, one-edge latency
    applyStimulus(1'b1, OP_R, 3'b000, 1'b0, 32'hFFFFFFFF, 32'h2, 1'b1, 32'h1, acc, w);
    waitOutput(acc, 10, 1'b0, lat);
    checkOutput("lat_add", 32'(lat), 32'd1);
    @(posedge CLK); #1;

    // SUB, SLT, SLTU
    applyStimulus(1'b1, OP_R, 3'b000, 1'b1, 32'd5, 32'd7, 1'b1, 32'hFFFFFFFE, acc, w);
    applyStimulus(1'b1, OP_R, 3'b010, 1'b1, 32'd5, 32'd7, 1'b1, 32'h1, acc, w);
    applyStimulus(1'b1, OP_R, 3'b011, 1'b0, 32'hFFFFFFFF, 32'h1, 1'b1, 32'h0, acc, w);
    // Non-ALU opcode performs ADD; OP-IMM with bit 30 set is still ADD
    applyStimulus(1'b1, 7'b1100011, 3'b111, 1'b1, 32'h10, 32'h22, 1'b1, 32'h32, acc, w);
    applyStimulus(1'b1, OP_I, 3'b000, 1'b1, 32'h10, 32'h22, 1'b1, 32'h32, acc, w);
    waitOutput(acc, 10, 1'b0, lat);
    @(posedge CLK); #1;

    // SRAI by 4 (upper DATA1 bits ignored), IN_READY low while shifting
    applyStimulus(1'b1, OP_I, 3'b101, 1'b1, 32'h80000000, 32'h404, 1'b1, 32'hF8000000, acc, w);
    waitOutput(acc, 40, 1'b1, lat);
    checkOutput("lat_srai", 32'(lat), 32'(SRAI_LAT));
    @(posedge CLK); #1;

    // Zero-amount shift finishes in one edge
    applyStimulus(1'b1, OP_R, 3'b001, 1'b0, 32'h1234ABCD, 32'hFFFFFFE0, 1'b1, 32'h1234ABCD, acc, w);
    waitOutput(acc, 10, 1'b0, lat);
    checkOutput("lat_shift0", 32'(lat), 32'd1);
    @(posedge CLK); #1;

    // Backpressure hold, then retire and accept on the same edge
    OUT_READY = 1'b0;
    applyStimulus(1'b1, OP_R, 3'b110, 1'b0, 32'hF0F00000, 32'h0000F0F0, 1'b1, 32'hF0F0F0F0, acc, w);
    waitOutput(acc, 10, 1'b0, lat);
    repeat (3) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      checkOutput("hold_valid", 32'(OUT_VALID), 32'h1);
      checkOutput("hold_result", RESULT, 32'hF0F0F0F0);
    end
    @(posedge CLK); #1;
    OUT_READY = 1'b1;
    applyStimulus(1'b1, OP_R, 3'b100, 1'b0, 32'hAAAA5555, 32'hFFFF0000, 1'b1, 32'h55555555, acc, w);
    checkOutput("b2b_wait", 32'(w), 32'h0);
    waitOutput(acc, 10, 1'b0, lat);
    checkOutput("lat_b2b", 32'(lat), 32'd1);
    @(posedge CLK); #1;

    // ALU_EN=0 bundle is consumed without output
    applyStimulus(1'b0, OP_R, 3'b000, 1'b0, 32'h1, 32'h1, 1'b0, 32'h0, acc, w);
    repeat (3) begin
      @(negedge CLK);
      checkOutput("noalu_out_valid", 32'(OUT_VALID), 32'h0);
      checkOutput("noalu_in_ready", 32'(IN_READY), 32'h1);
    end
    @(posedge CLK); #1;

    // Reset in the middle of a 31-bit SLL aborts it
    applyStimulus(1'b1, OP_R, 3'b001, 1'b0, 32'h1, 32'd31, 1'b0, 32'h0, acc, w);
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    @(negedge CLK);
    checkOutput("midrst_in_ready", 32'(IN_READY), 32'h0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    checkOutput("midrst_out_valid", 32'(OUT_VALID), 32'h0);
    checkOutput("midrst_result", RESULT, 32'h0);
    checkOutput("midrst_in_ready_after", 32'(IN_READY), 32'h1);
    repeat (35) @(posedge CLK);
    #1;

    // Random mix with random downstream backpressure
    randomReady = 1'b1;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 2))
        0: op = OP_R;
        1: op = OP_I;
        default: op = 7'($urandom);
      endcase
      f3 = 3'($urandom); f7 = 1'($urandom); a = $urandom; b = $urandom;
      en = ($urandom_range(0, 7) != 0);
      applyStimulus(en, op, f3, f7, a, b, en, expModel(op, f3, f7, a, b), acc, w);
    end
    randomReady = 1'b0;
    OUT_READY = 1'b1;
    n = 0;
    while (expQ.size() != 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    @(posedge CLK); #1;
    checkOutput("drain_empty", 32'(expQ.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/alu_execute.md
ALU_EXECUTE -- requirements
Module: alu_execute

Interface
REQ-001 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-003 SHALL have port IN_VALID  input  1  upstream operand bundle valid.
REQ-004 SHALL have port IN_READY  output  1  block can accept a bundle this cycle.
REQ-005 SHALL have ports DATA0, DATA1  input  32 each  operands from the operand-select stage.
REQ-006 SHALL have port ALU_EN  input  1  bundle carries an ALU operation.
REQ-007 SHALL have ports OPCODE  input  7, FUNCT3  input  3, FUNCT7_5  input  1 (instruction bit 30).
REQ-008 SHALL have port RESULT  output  32  registered result.
REQ-009 SHALL have port OUT_VALID  output  1  RESULT valid.
REQ-010 SHALL have port OUT_READY  input  1  downstream accepts RESULT.

Function
REQ-011 SHALL accept a bundle on a rising edge where IN_VALID=1 and IN_READY=1; a bundle with ALU_EN=0 SHALL be consumed and SHALL produce no output.
REQ-012 SHALL implement states IDLE, SHIFT, DONE; IN_READY = (IDLE) or (DONE and OUT_READY); OUT_VALID=1 only in DONE.
REQ-013 Op select: OPCODE 0110011 uses FUNCT3 with FUNCT7_5 selecting SUB (000) / SRA (101); OPCODE 0010011 uses FUNCT3, FUNCT7_5 selects SRA only for 101; any other OPCODE with ALU_EN=1 SHALL perform ADD.
REQ-014 FUNCT3: 000 ADD/SUB, 010 SLT signed, 011 SLTU, 100 XOR, 110 OR, 111 AND -> RESULT captured at accept edge, state -> DONE (1-cycle latency).
REQ-015 ADD/SUB SHALL be modulo 2^32, overflow discarded; SLT/SLTU SHALL return 32'h1 or 32'h0.
REQ-016 FUNCT3 001 SLL, 101 SRL/SRA: shift amount = DATA1[4:0], upper DATA1 bits ignored.
REQ-017 Shift with amount 0: RESULT=DATA0 at accept edge, state -> DONE.
REQ-018 Shift with amount N>0: state -> SHIFT, RESULT loaded with DATA0, one bit position per cycle, SRA replicating bit 31; after N SHIFT cycles state -> DONE; total latency N+1 edges from accept to OUT_VALID.
REQ-019 IN_READY SHALL be 0 throughout SHIFT; upstream bundles SHALL be held, not dropped.
REQ-020 In DONE with OUT_READY=0, RESULT and OUT_VALID SHALL hold unchanged.
REQ-021 In DONE with OUT_READY=1 and a new valid bundle, output retires and new bundle is accepted on the same edge (back-to-back, no bubble); without a new bundle state -> IDLE.
REQ-022 RESULT SHALL be stable and defined whenever OUT_VALID=1; value undefined otherwise not permitted: it SHALL hold last value.

Reset
REQ-023 RST=1 at an edge SHALL force state IDLE, OUT_VALID=0, RESULT=32'h0, shift counter 0; IN_READY=0 while RST=1.
REQ-024 RST during SHIFT or DONE SHALL abort the operation; no OUT_VALID for it afterward.
REQ-025 First edge after RST deasserts SHALL be able to accept a bundle.

Configuration
REQ-026 Macro ALU_EXECUTE_FAST_SHIFT_EN: when defined, all shifts SHALL complete as in REQ-014 (single-cycle barrel shift, SHIFT state unused); when undefined, REQ-017/REQ-018 iterative behaviour SHALL apply. All other behaviour identical.

Verification
REQ-027 ADD: OPCODE 0110011, FUNCT3 000, FUNCT7_5 0, DATA0=32'hFFFFFFFF, DATA1=32'h2 -> RESULT=32'h1, OUT_VALID one edge after accept.
REQ-028 SUB/SLT: OPCODE 0110011, FUNCT7_5 1, DATA0=5, DATA1=7 -> 32'hFFFFFFFE; FUNCT3 010 same operands -> 32'h1; SLTU DATA0=32'hFFFFFFFF, DATA1=1 -> 32'h0.
REQ-029 SRAI: OPCODE 0010011, FUNCT3 101, FUNCT7_5 1, DATA0=32'h80000000, DATA1=32'h404 -> RESULT=32'hF8000000 after 5 edges (1 edge if macro defined); IN_READY=0 during shift.
REQ-030 Backpressure: OUT_READY=0 for 3 cycles in DONE -> RESULT/OUT_VALID held; then OUT_READY=1 with next bundle valid -> retire and accept same edge.
REQ-031 Reset mid-shift: SLL amount 31 started, RST asserted 4 cycles later -> OUT_VALID=0, RESULT=0, IN_READY=1 on first cycle after RST deasserts.
REQ-032 ALU_EN=0 bundle with IN_VALID=1 -> consumed, OUT_VALID stays 0, state stays IDLE.
